// File: rtl/mem_defs.sv
// Shared definitions for the data-port arbiter and its byte-merge helper.
package mem_defs;
    localparam int unsigned WORD_LSB = 2;
    localparam int unsigned STRB_W   = 4;
    localparam int unsigned BYTE_W   = 8;
    localparam logic [STRB_W-1:0] FULL_STRB = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } state_t;

    // A strobe needs read-modify-write only when it selects some but not all bytes.
    function automatic logic is_partial(input logic [STRB_W-1:0] strb);
        return (strb != FULL_STRB) && (strb != '0);
    endfunction
endpackage

// File: rtl/wstrb_merge.sv
// Byte-lane merge of an old word with new data under a write strobe.
module wstrb_merge
    import mem_defs::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_old_word,
    input  logic [DATA_W-1:0] i_new_word,
    input  logic [STRB_W-1:0] i_wstrb,
    output logic [DATA_W-1:0] o_merged
);
    for (genvar b = 0; b < STRB_W; b++) begin : g_byte
        assign o_merged[b*BYTE_W +: BYTE_W] = i_wstrb[b] ? i_new_word[b*BYTE_W +: BYTE_W]
                                                         : i_old_word[b*BYTE_W +: BYTE_W];
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and access sequencer for the shared memory data port;
// partial-strobe writes are done as read-modify-write.
module dmem_arbiter
    import mem_defs::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [STRB_W-1:0] req0_wstrb,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_rvalid,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [STRB_W-1:0] req1_wstrb,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_rvalid,
    output logic [DATA_W-1:0] req1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ren,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wen,
    output logic [STRB_W-1:0] mem_wstrb,
    output logic [DATA_W-1:0] mem_wdata
);
    state_t             r_state;
    state_t             w_next;
    logic               r_last_grant;
    logic               r_id;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [STRB_W-1:0]  r_wstrb;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_rdata;
    logic [DATA_W-1:0]  r_merge;
    logic [DATA_W-1:0]  w_merged;
    logic               w_grant0;
    logic               w_grant1;
    logic               w_accept;

    // Ties go to the requester that was not granted last.
    assign w_grant0 = req0_valid && (!req1_valid || r_last_grant);
    assign w_grant1 = req1_valid && (!req0_valid || !r_last_grant);
    assign w_accept = (r_state == IDLE) && (w_grant0 || w_grant1);

    assign mem_wstrb = FULL_STRB;

    wstrb_merge #(.DATA_W(DATA_W)) u_merge (
        .i_old_word (mem_rdata),
        .i_new_word (r_wdata),
        .i_wstrb    (r_wstrb),
        .o_merged   (w_merged)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
        end else begin
            r_state <= w_next;
            if (w_accept) r_last_grant <= w_grant1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_id    <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wstrb <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_merge <= '0;
        end else begin
            if (w_accept) begin
                r_id    <= w_grant1;
                r_we    <= w_grant1 ? req1_we    : req0_we;
                r_addr  <= w_grant1 ? req1_addr  : req0_addr;
                r_wstrb <= w_grant1 ? req1_wstrb : req0_wstrb;
                r_wdata <= w_grant1 ? req1_wdata : req0_wdata;
            end
            // Response carries the read word, or the pre-write word of a merge.
            if (r_state == ACCESS) begin
                r_rdata <= (r_we && !is_partial(r_wstrb)) ? '0 : mem_rdata;
                r_merge <= w_merged;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        req0_rvalid = 1'b0;
        req1_rvalid = 1'b0;
        req0_rdata  = '0;
        req1_rdata  = '0;
        mem_addr    = '0;
        mem_ren     = 1'b0;
        mem_wen     = 1'b0;
        mem_wdata   = '0;

        unique case (r_state)
            IDLE:    if (w_grant0 || w_grant1) w_next = ACCESS;
            ACCESS:  w_next = (r_we && is_partial(r_wstrb)) ? WRITE : RESP;
            WRITE:   w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase

        // Nothing is driven toward requesters or memory while reset is asserted.
        if (rst_n) begin
            unique case (r_state)
                IDLE: begin
                    req0_ready = w_grant0;
                    req1_ready = w_grant1;
                end
                ACCESS: begin
                    mem_addr = r_addr;
                    mem_ren  = 1'b1;
                    if (r_we && (r_wstrb == FULL_STRB)) begin
                        mem_wen   = 1'b1;
                        mem_wdata = r_wdata;
                    end
                end
                WRITE: begin
                    mem_addr  = r_addr;
                    mem_wen   = 1'b1;
                    mem_wdata = r_merge;
                end
                RESP: begin
                    if (r_id) begin
                        req1_rvalid = 1'b1;
                        req1_rdata  = r_rdata;
                    end else begin
                        req0_rvalid = 1'b1;
                        req0_rdata  = r_rdata;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vectors, corner sequences and
// random traffic checked against a transaction-level model of the data port.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_we, req0_rvalid;
    logic [31:0] req0_addr, req0_wdata, req0_rdata;
    logic [3:0]  req0_wstrb;
    logic        req1_valid, req1_ready, req1_we, req1_rvalid;
    logic [31:0] req1_addr, req1_wdata, req1_rdata;
    logic [3:0]  req1_wstrb;
    logic [31:0] mem_addr, mem_rdata, mem_wdata;
    logic        mem_ren, mem_wen;
    logic [3:0]  mem_wstrb;

    logic [31:0] mem_arr [256];
    logic [31:0] ref_mem [256];
    bit          mem_init = 1'b0;
    bit          ref_init = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wstrb(req0_wstrb), .req0_wdata(req0_wdata),
        .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wstrb(req1_wstrb), .req1_wdata(req1_wdata),
        .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
        .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_rdata(mem_rdata),
        .mem_wen(mem_wen), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] preload_val(input int i);
        case (i)
            64:      return 32'hDEADBEEF;
            65:      return 32'h11223344;
            67:      return 32'h55667788;
            default: return (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
        endcase
    endfunction

    // Memory array behind the data port: combinational read, write on the clock edge.
    assign mem_rdata = mem_arr[mem_addr[9:2]];
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= preload_val(i);
            mem_init <= 1'b1;
        end else if (mem_wen) begin
            mem_arr[mem_addr[9:2]] <= mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
        end
    endtask

    // Transaction-level model: one access in flight, fixed latencies from acceptance.
    int          free_cyc = 0, resp_due = -1, ren_due = -1, wr_due = -1;
    bit          last_ref = 1'b1, resp_id;
    logic [31:0] resp_data, ren_addr, wr_addr, wr_data;
    bit          m_e0, m_e1, m_id, m_we;
    logic [31:0] m_addr, m_wd, m_old, m_new, m_rd;
    logic [3:0]  m_strb;
    int          m_lat;

    always @(negedge clk) begin
        if (!ref_init) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = preload_val(i);
            ref_init = 1'b1;
        end
        if (!rst_n) begin
            chk1("rst_ready0", req0_ready, 1'b0);
            chk1("rst_ready1", req1_ready, 1'b0);
            chk1("rst_rvalid0", req0_rvalid, 1'b0);
            chk1("rst_rvalid1", req1_rvalid, 1'b0);
            chk1("rst_mem_wen", mem_wen, 1'b0);
            chk1("rst_mem_ren", mem_ren, 1'b0);
            resp_due = -1; ren_due = -1; wr_due = -1;
            last_ref = 1'b1;
            free_cyc = cyc + 1;
        end else begin
            m_e0 = 1'b0; m_e1 = 1'b0;
            if (cyc >= free_cyc) begin
                if (req0_valid && req1_valid) begin
                    m_e0 = last_ref;
                    m_e1 = !last_ref;
                end else begin
                    m_e0 = req0_valid;
                    m_e1 = req1_valid;
                end
            end
            chk1("ready0", req0_ready, m_e0);
            chk1("ready1", req1_ready, m_e1);
            chk1("rvalid0", req0_rvalid, (cyc == resp_due) && !resp_id);
            chk1("rvalid1", req1_rvalid, (cyc == resp_due) && resp_id);
            if (cyc == resp_due) chk("rdata", resp_id ? req1_rdata : req0_rdata, resp_data);
            chk1("mem_ren", mem_ren, cyc == ren_due);
            if (cyc == ren_due) chk("ren_addr", mem_addr & ~32'h3, ren_addr & ~32'h3);
            chk1("mem_wen", mem_wen, cyc == wr_due);
            if (cyc == wr_due) begin
                chk("wen_addr", mem_addr & ~32'h3, wr_addr & ~32'h3);
                chk("wen_data", mem_wdata, wr_data);
                chk("wen_strb", 32'(mem_wstrb), 32'hF);
                ref_mem[wr_addr[9:2]] = wr_data;
            end
            if (m_e0 || m_e1) begin
                m_id   = m_e1;
                m_we   = m_id ? req1_we    : req0_we;
                m_addr = m_id ? req1_addr  : req0_addr;
                m_strb = m_id ? req1_wstrb : req0_wstrb;
                m_wd   = m_id ? req1_wdata : req0_wdata;
                m_old  = ref_mem[m_addr[9:2]];
                m_lat  = 2;
                m_rd   = m_old;
                if (m_we) begin
                    for (int b = 0; b < 4; b++)
                        m_new[8*b +: 8] = m_strb[b] ? m_wd[8*b +: 8] : m_old[8*b +: 8];
                    if (m_strb == 4'hF) begin
                        m_rd = 32'h0;
                        wr_due = cyc + 1;
                    end else if (m_strb == 4'h0) begin
                        m_rd = 32'h0;
                    end else begin
                        m_lat = 3;
                        wr_due = cyc + 2;
                    end
                    wr_addr = m_addr;
                    wr_data = m_new;
                end
                resp_due  = cyc + m_lat;
                resp_id   = m_id;
                resp_data = m_rd;
                ren_due   = cyc + 1;
                ren_addr  = m_addr;
                free_cyc  = cyc + m_lat + 1;
                last_ref  = m_id;
            end
        end
    end

    task automatic drive(input bit id, input bit v, input bit we, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d);
        if (id) begin
            req1_valid = v; req1_we = we; req1_addr = a; req1_wstrb = s; req1_wdata = d;
        end else begin
            req0_valid = v; req0_we = we; req0_addr = a; req0_wstrb = s; req0_wdata = d;
        end
    endtask

    task automatic wait_ready(input bit id, output int t);
        bit ok = 1'b0;
        t = -1;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) begin ok = 1'b1; t = cyc; end
        end
        if (!ok) chk1("ready_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_rvalid(input bit id, output int t, output logic [31:0] rd);
        bit ok = 1'b0;
        t = -1; rd = 32'h0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (id ? req1_rvalid : req0_rvalid) begin
                ok = 1'b1; t = cyc; rd = id ? req1_rdata : req0_rdata;
            end
        end
        if (!ok) chk1("rvalid_timeout", 1'b0, 1'b1);
    endtask

    task automatic issue(input bit id, input bit we, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, output int lat, output logic [31:0] rd);
        int ta, tr;
        @(posedge clk); #1;
        drive(id, 1'b1, we, a, s, d);
        wait_ready(id, ta);
        @(posedge clk); #1;
        drive(id, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        wait_rvalid(id, tr, rd);
        lat = tr - ta;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk1({tag, "_ready0"}, req0_ready, 1'b0);
        chk1({tag, "_ready1"}, req1_ready, 1'b0);
        chk1({tag, "_rvalid0"}, req0_rvalid, 1'b0);
        chk1({tag, "_rvalid1"}, req1_rvalid, 1'b0);
        chk({tag, "_rdata0"}, req0_rdata, 32'h0);
        chk({tag, "_rdata1"}, req1_rdata, 32'h0);
        chk1({tag, "_mem_ren"}, mem_ren, 1'b0);
        chk1({tag, "_mem_wen"}, mem_wen, 1'b0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        chk({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'hF);
    endtask

    task automatic rand_req(input bit id);
        logic [31:0] a;
        logic [3:0]  s;
        a = 32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
            0:       s = 4'hF;
            1:       s = 4'h0;
            default: s = 4'($urandom_range(1, 14));
        endcase
        drive(id, 1'b1, 1'($urandom_range(0, 1)), a, s, $urandom);
    endtask

    typedef struct {
        bit          id;
        bit          we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t        vecs[10];
    bit          exp_order[6];
    bit          got_order[6];
    int          n, lat, t0, t1;
    logic [31:0] rd;
    bit          a0, a1;

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h100, 4'h0, 32'h0,        32'hDEADBEEF, 2};
        vecs[1] = '{1'b1, 1'b1, 32'h104, 4'h2, 32'h0000AA00, 32'h11223344, 3};
        vecs[2] = '{1'b0, 1'b0, 32'h104, 4'h0, 32'h0,        32'h1122AA44, 2};
        vecs[3] = '{1'b1, 1'b1, 32'h108, 4'hF, 32'hCAFEF00D, 32'h0,        2};
        vecs[4] = '{1'b0, 1'b0, 32'h108, 4'h0, 32'h0,        32'hCAFEF00D, 2};
        vecs[5] = '{1'b1, 1'b1, 32'h10C, 4'h0, 32'hFFFFFFFF, 32'h0,        2};
        vecs[6] = '{1'b0, 1'b0, 32'h10C, 4'h0, 32'h0,        32'h55667788, 2};
        vecs[7] = '{1'b1, 1'b0, 32'h101, 4'h0, 32'h0,        32'hDEADBEEF, 2};
        vecs[8] = '{1'b0, 1'b1, 32'h100, 4'h9, 32'hAABBCCDD, 32'hDEADBEEF, 3};
        vecs[9] = '{1'b1, 1'b0, 32'h100, 4'h0, 32'h0,        32'hAAADBEDD, 2};
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("in_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_vals("after_reset");

        // Fairness: both requesters continuously valid.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 32'h100, 4'h0, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h104, 4'h0, 32'h0);
        n = 0;
        for (int k = 0; k < 60 && n < 6; k++) begin
            @(negedge clk);
            if (req0_ready) begin got_order[n] = 1'b0; n++; end
            else if (req1_ready) begin got_order[n] = 1'b1; n++; end
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        chk("fair_count", 32'(n), 32'd6);
        for (int i = 0; i < 6; i++)
            chk1($sformatf("fair_grant%0d", i), got_order[i], exp_order[i]);

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].id, vecs[i].we, vecs[i].addr, vecs[i].strb, vecs[i].wdata, lat, rd);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
        end

        // New valid raised during own RESP is taken in the following IDLE cycle.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 32'h100, 4'h0, 32'h0);
        wait_ready(1'b0, t0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 32'h104, 4'h0, 32'h0);
        @(negedge clk);
        chk1("pipe_rvalid", req0_rvalid, 1'b1);
        chk("pipe_rdata", req0_rdata, 32'hAAADBEDD);
        chk1("pipe_ready_in_resp", req0_ready, 1'b0);
        @(negedge clk);
        chk1("pipe_accept", req0_ready, 1'b1);
        t0 = cyc;
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        wait_rvalid(1'b0, t1, rd);
        chk("pipe2_lat", 32'(t1 - t0), 32'd2);
        chk("pipe2_rdata", rd, 32'h1122AA44);

        // Reset asserted in the WRITE cycle of a partial write.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, 32'h108, 4'h4, 32'h00990000);
        wait_ready(1'b0, t0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk1("rstw_mem_wen", mem_wen, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_vals("rstw_next");
        chk("rstw_mem_kept", mem_arr[66], 32'hCAFEF00D);
        @(negedge clk);
        chk1("rstw_no_rvalid", req0_rvalid, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 32'h108, 4'h0, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h104, 4'h0, 32'h0);
        @(negedge clk);
        chk1("rstw_tie_req0", req0_ready, 1'b1);
        chk1("rstw_tie_req1", req1_ready, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        wait_ready(1'b1, t0);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (4) @(posedge clk);

        // Random traffic from both requesters with occasional resets.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            a0 = req0_ready;
            a1 = req1_ready;
            @(posedge clk); #1;
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 79) == 0) rst_n = 1'b0;
            if (a0) req0_valid = 1'b0;
            if (a1) req1_valid = 1'b0;
            if (!req0_valid && $urandom_range(0, 2) == 0) rand_req(1'b0);
            if (!req1_valid && $urandom_range(0, 2) == 0) rand_req(1'b1);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        repeat (6) @(posedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates and sequences the shared data port (port1) of the unified `Memory` block between two requesters: the CPU data side (req0) and the debug/DMA loader (req1). Granting is round-robin with valid/ready handshakes. Byte-strobed writes are implemented as read-modify-write, because the memory array only performs full-word writes. Instruction fetch (port0) bypasses this block.

## Interface
- `ADDR_W`, 32, address width (byte addresses)
- `DATA_W`, 32, data width (fixed at 4 bytes; other values unsupported)

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `reqN_valid`  in  1  request N pending (N = 0, 1)
- `reqN_ready`  out  1  request N accepted this cycle
- `reqN_we`  in  1  1 = write, 0 = read
- `reqN_addr`  in  ADDR_W  byte address; bits [1:0] ignored
- `reqN_wstrb`  in  4  byte enables for writes
- `reqN_wdata`  in  DATA_W  write data
- `reqN_rvalid`  out  1  one-cycle completion pulse (reads and writes)
- `reqN_rdata`  out  DATA_W  read data; valid only with `reqN_rvalid`
- `mem_addr`  out  ADDR_W  to `port1_addr`
- `mem_ren`  out  1  to `port1_ren`
- `mem_rdata`  in  DATA_W  from `port1_rdata` (combinational read)
- `mem_wen`  out  1  to `port1_wen`
- `mem_wstrb`  out  4  to `port1_wstrb`; always 4'hF when `mem_wen`
- `mem_wdata`  out  DATA_W  to `port1_wdata`

## Operation
- FSM states: IDLE, ACCESS, WRITE, RESP. Reset state is IDLE.
- **IDLE:**
  - Grant one valid requester. With both valid, grant the one not granted last. `last_grant` resets to 1, so req0 wins the first tie.
  - `reqN_ready` = IDLE & granted & `rst_n`. It may depend combinationally on both `valid` inputs.
  - On acceptance: latch `we`, `addr`, `wstrb`, `wdata` and the grant id; update `last_grant`; go to ACCESS.
- **ACCESS:**
  - `mem_addr` = latched address; `mem_ren` = 1.
  - Read: capture `mem_rdata` into the response register, then go to RESP.
  - Write with `wstrb` = 4'hF: assert `mem_wen` with the latched `wdata`, then go to RESP.
  - Write with `wstrb` = 4'h0: no memory write; go to RESP.
  - Partial write: merge `mem_rdata` with `wdata` per strobe byte (strobe bit set takes `wdata`) into the merge register, then go to WRITE.
- **WRITE:** `mem_wen` = 1, `mem_wdata` = merge register, then go to RESP.
- **RESP:**
  - Pulse `rvalid` of the latched id for one cycle.
  - `rdata` = read word for reads, and the pre-write word for partial writes. It is 0 for full or zero-strobe writes.
  - Return to IDLE.
- Requesters hold all request fields stable and keep `valid` high until `ready`. The arbiter does not check this.
- A requester may raise its next `valid` before its `rvalid`. That request is accepted on the next IDLE cycle, subject to round-robin.
- Outputs when not driving an access: `mem_ren`/`mem_wen` = 0, `mem_addr`/`mem_wdata` = 0.

## Timing
- Accept at cycle T.
  - Read, full write or zero-strobe write: ACCESS at T+1, `rvalid` at T+2.
  - Partial write: memory write on the edge ending T+2, `rvalid` at T+3.
- Throughput: 1 request per 3 cycles, or 4 for partial writes. There is no back-to-back accept; `ready` is low in ACCESS, WRITE and RESP.
- Memory contents change on the edge ending the cycle with `mem_wen` = 1. A read accepted afterwards sees the new data.
- Reset values:
  - `ready`, `rvalid`, `mem_ren`, `mem_wen` = 0
  - `rdata`, `mem_addr`, `mem_wdata` = 0
  - `mem_wstrb` = 4'hF
  - `last_grant` = 1
- Reset mid-operation: the transaction is abandoned with no `rvalid`. `mem_wen` and `mem_ren` are gated by `rst_n`, so no memory write occurs on an edge where `rst_n` = 0, including in WRITE.
- Simultaneous arrival of a new `valid` and an `rvalid` for the same requester is legal. They are independent.

## Structure
- Shared defs header/package `mem_defs`:
  - state encoding: IDLE = 2'd0, ACCESS = 1, WRITE = 2, RESP = 3
  - `WORD_LSB` = 2
  - `FULL_STRB` = 4'hF
- Sub-module `wstrb_merge`: combinational byte merge of old word, new word and strobe (4 muxes). It is reusable by future cache write paths.

## Test plan
- **Read:** preload word 0x100 = 0xDEADBEEF; req0 reads 0x100 → `req0_rvalid` 2 cycles after accept, `rdata` = 0xDEADBEEF.
- **Partial write:** req1 writes 0x0000AA00 to 0x104 with `wstrb` 4'b0010 over an old 0x11223344 → one `mem_wen` pulse with 0x1122AA44; `rvalid` at T+3; a subsequent read returns 0x1122AA44.
- **Full and zero-strobe writes:** full write of 0xCAFEF00D with strobe F → `mem_wen` at T+1, `rvalid` at T+2, no read-modify-write. `wstrb` 0 → no `mem_wen`, `rvalid` at T+2, memory unchanged.
- **Fairness:** both valid continuously for 6 requests → grants alternate 0,1,0,1,0,1, starting with req0 after reset.
- **Reset in WRITE:** assert `rst_n` = 0 in the WRITE cycle of a partial write → no memory update, no `rvalid`, all outputs at reset values the next cycle; the first tie afterwards grants req0.
- **Pipelined valid:** req0 asserts a new `valid` during its own RESP → accepted in the following IDLE cycle; `ready` is never high outside IDLE.
